// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: fixed-priority two-port arbiter for the 4K x 32 system SRAM.
// Define SRAM_ARB_STARVE_GUARD_EN to build the port-1 wait counter and forced grant.
module sram_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [3:0]    we0,
  input  logic [3:0]    we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } state_t;

  localparam logic [7:0] LMAX = 8'(LOCK_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic [7:0] hold_inc;
  logic       pri0_q;
  logic       pri0_d;
  logic       pri1_q;
  logic       pri1_d;
  logic       g0;
  logic       g1;
  logic       starve;
  logic       rv0_q;
  logic       rv1_q;

  assign hold_inc = hold_q + 8'd1;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  logic [7:0] wait1_q;

  assign starve = req1 && (wait1_q >= SLIM);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait1_q <= 8'd0;
    end else if (!req1 || g1) begin
      wait1_q <= 8'd0;
    end else if (wait1_q != 8'hFF) begin
      wait1_q <= wait1_q + 8'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // pri*_q: one-cycle priority handed to the other port after a forced release
  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state_q;
    hold_d  = hold_q;
    pri0_d  = 1'b0;
    pri1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pri0_q && req0) begin
          g0 = 1'b1;
        end else if (pri1_q && req1) begin
          g1 = 1'b1;
        end else if (starve) begin
          g1 = 1'b1;
        end else if (req0) begin
          g0 = 1'b1;
        end else if (req1) begin
          g1 = 1'b1;
        end
        if (g0 && lock0) begin
          if (LMAX == 8'd1) begin
            pri1_d = 1'b1;
          end else begin
            state_d = LOCK0;
            hold_d  = 8'd1;
          end
        end
        if (g1 && lock1) begin
          if (LMAX == 8'd1) begin
            pri0_d = 1'b1;
          end else begin
            state_d = LOCK1;
            hold_d  = 8'd1;
          end
        end
      end
      LOCK0: begin
        if (!req0) begin
          state_d = IDLE;
        end else begin
          g0     = 1'b1;
          hold_d = hold_inc;
          if (!lock0) begin
            state_d = IDLE;
          end else if (hold_inc >= LMAX) begin
            state_d = IDLE;
            pri1_d  = 1'b1;
          end
        end
      end
      LOCK1: begin
        if (!req1) begin
          state_d = IDLE;
        end else begin
          g1     = 1'b1;
          hold_d = hold_inc;
          if (!lock1) begin
            state_d = IDLE;
          end else if (hold_inc >= LMAX) begin
            state_d = IDLE;
            pri0_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (HRESET) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      pri0_q  <= 1'b0;
      pri1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pri0_q  <= pri0_d;
      pri1_q  <= pri1_d;
      rv0_q   <= g0 && (we0 == 4'h0);
      rv1_q   <= g1 && (we1 == 4'h0);
    end
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 4'h0;
    ram_a  = '0;
    ram_di = '0;
    unique case (1'b1)
      g0: begin
        ram_en = 1'b1;
        ram_we = we0;
        ram_a  = addr0;
        ram_di = wdata0;
      end
      g1: begin
        ram_en = 1'b1;
        ram_we = we1;
        ram_a  = addr1;
        ram_di = wdata1;
      end
      default: begin
      end
    endcase
  end

  assign gnt0    = g0;
  assign gnt1    = g1;
  // a read in flight when reset hits must not surface
  assign rvalid0 = rv0_q && !HRESET;
  assign rvalid1 = rv1_q && !HRESET;
  assign rdata0  = ram_do;
  assign rdata1  = ram_do;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed + random checks of sram_port_arbiter
// against a rule-level reference model and a behavioural RAM.
module tb_sram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SL = 8;
  localparam int LM = 16;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req0, req1, lock0, lock1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  sram_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  // behavioural single-port RAM macro, 1-cycle read
  logic [DW-1:0] ram [0:4095];
  always @(posedge HCLK) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      if (ram_we == 4'h0) ram_do <= ram[ram_a];
    end
  end

  // reference model state
  logic [DW-1:0] exp_mem [0:4095];
  int            m_owner = -1;
  int            m_hold  = 0;
  int            m_w1    = 0;
  int            m_pri   = -1;
  bit            m_rv0   = 0;
  bit            m_rv1   = 0;
  logic [DW-1:0] m_rd0, m_rd1;

  logic          obs_g0, obs_g1, obs_rv0, obs_en;
  logic [3:0]    obs_we;
  logic [AW-1:0] obs_a;
  logic [DW-1:0] obs_di, obs_rd0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (HRESET) return -1;
    if (m_owner == 0) return req0 ? 0 : -1;
    if (m_owner == 1) return req1 ? 1 : -1;
    if (m_pri == 0 && req0) return 0;
    if (m_pri == 1 && req1) return 1;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    if (req1 && m_w1 >= SL) return 1;
`endif
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic mem_write(input logic [AW-1:0] a, input logic [3:0] w,
                           input logic [DW-1:0] d);
    for (int b = 0; b < 4; b++)
      if (w[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_update(input int g);
    int   npri;
    logic lk;
    if (HRESET) begin
      m_owner = -1; m_hold = 0; m_w1 = 0; m_pri = -1;
      m_rv0 = 0; m_rv1 = 0;
      return;
    end
    npri  = -1;
    m_rv0 = (g == 0) && (we0 == 4'h0);
    m_rv1 = (g == 1) && (we1 == 4'h0);
    if (m_rv0) m_rd0 = exp_mem[addr0];
    if (m_rv1) m_rd1 = exp_mem[addr1];
    if (g == 0) mem_write(addr0, we0, wdata0);
    if (g == 1) mem_write(addr1, we1, wdata1);
    if (m_owner >= 0) begin
      lk = (m_owner == 0) ? lock0 : lock1;
      if (g == m_owner) begin
        m_hold++;
        if (!lk) m_owner = -1;
        else if (m_hold >= LM) begin
          npri    = 1 - m_owner;
          m_owner = -1;
        end
      end else begin
        m_owner = -1;
      end
    end else if (g >= 0) begin
      lk = (g == 0) ? lock0 : lock1;
      if (lk) begin
        if (LM == 1) npri = 1 - g;
        else begin
          m_owner = g;
          m_hold  = 1;
        end
      end
    end
    m_pri = npri;
    if (req1 && g != 1) m_w1 = (m_w1 < 255) ? m_w1 + 1 : 255;
    else m_w1 = 0;
  endtask

  // one cycle: sample and check at negedge, advance model, return after posedge
  task automatic tick();
    int g;
    bit erv0, erv1;
    @(negedge HCLK);
    g    = model_grant();
    erv0 = m_rv0 && !HRESET;
    erv1 = m_rv1 && !HRESET;
    obs_g0 = gnt0; obs_g1 = gnt1; obs_rv0 = rvalid0; obs_rd0 = rdata0;
    obs_en = ram_en; obs_we = ram_we; obs_a = ram_a; obs_di = ram_di;
    chk("gnt0", gnt0, g == 0);
    chk("gnt1", gnt1, g == 1);
    chk("rvalid0", rvalid0, erv0);
    chk("rvalid1", rvalid1, erv1);
    if (erv0) chk("rdata0", rdata0, m_rd0);
    if (erv1) chk("rdata1", rdata1, m_rd1);
    chk("ram_en", ram_en, g >= 0);
    if (g == 0) begin
      chk("ram_a0", ram_a, addr0);
      chk("ram_we0", ram_we, we0);
      if (we0 != 4'h0) chk("ram_di0", ram_di, wdata0);
    end else if (g == 1) begin
      chk("ram_a1", ram_a, addr1);
      chk("ram_we1", ram_we, we1);
      if (we1 != 4'h0) chk("ram_di1", ram_di, wdata1);
    end else begin
      chk("ram_we_idle", ram_we, 4'h0);
    end
    if (HRESET) begin
      chk("rst_ram_a", ram_a, 0);
      chk("rst_ram_di", ram_di, 0);
    end
    model_update(g);
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [AW-1:0] raddr();
    return AW'(12'h010 + 12'($urandom_range(0, 15)));
  endfunction

  initial begin
    HRESET = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick();
    tick();
    HRESET = 1'b0;

    // prefill the working window, then the single-read case
    for (int a = 0; a < 16; a++) begin
      req0 = 1; we0 = 4'hF; addr0 = AW'(16 + a); wdata0 = $urandom;
      tick();
    end
    addr0 = 12'h010; wdata0 = 32'hDEADBEEF;
    tick();
    we0 = 4'h0;
    tick();
    chk("rd_gnt0", obs_g0, 1);
    req0 = 0;
    tick();
    chk("rd_rvalid0", obs_rv0, 1);
    chk("rd_rdata0", obs_rd0, 32'hDEADBEEF);
    tick();

    // contention: both ports held, reads at random addresses
    req0 = 1; req1 = 1; we0 = 0; we1 = 0;
    for (int i = 0; i < 300; i++) begin
      addr0 = raddr(); addr1 = raddr();
      tick();
`ifdef SRAM_ARB_STARVE_GUARD_EN
      chk("cont_g1", obs_g1, (i % 9) == 8);
      chk("cont_g0", obs_g0, (i % 9) != 8);
`else
      chk("cont_g1", obs_g1, 0);
`endif
    end
    req0 = 0; req1 = 0;
    tick();
    tick();

    // lock: 4 locked reads + 1 unlocked on port 1, port 0 waiting
    req1 = 1; lock1 = 1; addr1 = raddr();
    tick();
    chk("lock_g1_0", obs_g1, 1);
    req0 = 1; addr0 = raddr();
    for (int i = 1; i < 5; i++) begin
      lock1 = (i < 4); addr1 = raddr();
      tick();
      chk("lock_g1", obs_g1, 1);
      chk("lock_g0", obs_g0, 0);
    end
    req1 = 0; lock1 = 0;
    tick();
    chk("lock_after_g0", obs_g0, 1);
    req0 = 0;
    tick();

    // forced release after LM grants
    req1 = 1; lock1 = 1; addr1 = raddr();
    tick();
    req0 = 1;
    for (int i = 1; i < LM; i++) begin
      addr1 = raddr();
      tick();
      chk("frel_g1", obs_g1, 1);
    end
    tick();
    chk("frel_g0", obs_g0, 1);
    chk("frel_g1_off", obs_g1, 0);
    req0 = 0;
    tick();
    chk("frel_relock", obs_g1, 1);
    req1 = 0; lock1 = 0;
    tick();

    // reset mid-lock with a read in flight
    req0 = 1; lock0 = 1; we0 = 0; addr0 = raddr();
    tick();
    chk("rst_pre_g0", obs_g0, 1);
    HRESET = 1;
    tick();
    chk("rst_rv0", obs_rv0, 0);
    chk("rst_en", obs_en, 0);
    chk("rst_we", obs_we, 0);
    chk("rst_a", obs_a, 0);
    chk("rst_di", obs_di, 0);
    HRESET = 0; req0 = 0; lock0 = 0; req1 = 1; addr1 = raddr();
    tick();
    chk("rst_idle_g1", obs_g1, 1);
    req1 = 0;
    tick();

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      HRESET = ($urandom_range(0, 99) == 0);
      req0   = ($urandom_range(0, 9) < 7);
      req1   = ($urandom_range(0, 9) < 7);
      lock0  = $urandom_range(0, 1) != 0;
      lock1  = $urandom_range(0, 1) != 0;
      we0    = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(1, 15));
      we1    = $urandom_range(0, 1) != 0 ? 4'h0 : 4'($urandom_range(1, 15));
      addr0  = raddr();
      addr1  = raddr();
      wdata0 = $urandom;
      wdata1 = $urandom;
      tick();
    end
    HRESET = 0; req0 = 0; req1 = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
